// File: rtl/zero_skip_dot_sequencer.sv
// Dot-product sequencer: streams operand pairs through a zero-skipping multiplier,
// accumulates the products and counts how many were skipped because an operand was zero.

module zero_detect_mult (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        valid_out,
    output logic [15:0] result,
    output logic        skipped
);
    logic        valid_q, valid_d;
    logic [15:0] result_q, result_d;
    logic        skipped_q, skipped_d;
    logic        zero_c;

    // A zero operand bypasses the multiply and is flagged for sparsity statistics
    always_comb begin
        zero_c    = (a == 8'd0) || (b == 8'd0);
        valid_d   = valid_in;
        result_d  = zero_c ? 16'd0 : 16'(a) * 16'(b);
        skipped_d = valid_in & zero_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            result_q  <= 16'd0;
            skipped_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            result_q  <= result_d;
            skipped_q <= skipped_d;
        end
    end

    assign valid_out = valid_q;
    assign result    = result_q;
    assign skipped   = skipped_q;
endmodule

module zero_skip_dot_sequencer #(
    parameter int unsigned LEN_W = 8,
    parameter int unsigned ACC_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] length,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    output logic             busy,
    output logic             done,
    output logic [ACC_W-1:0] acc_out,
    output logic [LEN_W-1:0] skip_count
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] issue_cnt_q, issue_cnt_d;
    logic [LEN_W-1:0] retire_cnt_q, retire_cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [LEN_W-1:0] skip_q, skip_d;
    logic             in_ready_q, in_ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             mul_valid_in_c;
    logic             mul_valid_out;
    logic [15:0]      mul_result;
    logic             mul_skipped;

    zero_detect_mult u_mult (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (mul_valid_in_c),
        .a         (in_a),
        .b         (in_b),
        .valid_out (mul_valid_out),
        .result    (mul_result),
        .skipped   (mul_skipped)
    );

    always_comb begin
        state_d        = state_q;
        len_d          = len_q;
        issue_cnt_d    = issue_cnt_q;
        retire_cnt_d   = retire_cnt_q;
        acc_d          = acc_q;
        skip_d         = skip_q;
        mul_valid_in_c = 1'b0;

        // Retire path is independent of state so the pipeline always drains
        if (mul_valid_out) begin
            acc_d        = acc_q + ACC_W'(mul_result);
            skip_d       = skip_q + LEN_W'(mul_skipped);
            retire_cnt_d = retire_cnt_q + LEN_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d  = '0;
                    skip_d = '0;
                    if (length != '0) begin
                        len_d        = length;
                        issue_cnt_d  = '0;
                        retire_cnt_d = '0;
                        state_d      = S_RUN;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_RUN: begin
                if (in_valid && in_ready_q) begin
                    mul_valid_in_c = 1'b1;
                    issue_cnt_d    = issue_cnt_q + LEN_W'(1);
                    if (issue_cnt_q + LEN_W'(1) == len_q) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (retire_cnt_q == len_q) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        in_ready_d = (state_d == S_RUN);
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            issue_cnt_q  <= '0;
            retire_cnt_q <= '0;
            acc_q        <= '0;
            skip_q       <= '0;
            in_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            issue_cnt_q  <= issue_cnt_d;
            retire_cnt_q <= retire_cnt_d;
            acc_q        <= acc_d;
            skip_q       <= skip_d;
            in_ready_q   <= in_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign acc_out    = acc_q;
    assign skip_count = skip_q;
endmodule

// File: tb/tb_zero_skip_dot_sequencer.sv
// Directed bench for zero_skip_dot_sequencer; a 16-bit-accumulator copy shares all inputs.

module tb_zero_skip_dot_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  length;
    logic        in_valid;
    logic [7:0]  in_a;
    logic [7:0]  in_b;

    logic        in_ready, busy, done;
    logic [31:0] acc_out;
    logic [7:0]  skip_count;
    logic        in_ready16, busy16, done16;
    logic [15:0] acc_out16;
    logic [7:0]  skip_count16;

    int total = 0;
    int bad   = 0;
    int hs_cnt = 0;
    int done_cnt = 0;
    int ready_seen = 0;
    int lat;

    always #5 clk = ~clk;

    zero_skip_dot_sequencer #(.LEN_W(8), .ACC_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .length(length),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .busy(busy), .done(done), .acc_out(acc_out), .skip_count(skip_count)
    );

    zero_skip_dot_sequencer #(.LEN_W(8), .ACC_W(16)) dut16 (
        .clk(clk), .rst(rst), .start(start), .length(length),
        .in_valid(in_valid), .in_ready(in_ready16), .in_a(in_a), .in_b(in_b),
        .busy(busy16), .done(done16), .acc_out(acc_out16), .skip_count(skip_count16)
    );

    // Inputs change just after posedge, so the negedge sees stable handshakes
    always @(negedge clk) begin
        if (in_valid && in_ready) hs_cnt++;
        if (done) done_cnt++;
        if (in_ready) ready_seen++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_start(input logic [7:0] len);
        start  = 1'b1;
        length = len;
        @(posedge clk); #1;
        start  = 1'b0;
    endtask

    task automatic send_pair(input logic [7:0] a, input logic [7:0] b, input int gap);
        bit ok;
        ok = 1'b0;
        in_a = a; in_b = b; in_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("ready_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int g = 0; g < gap; g++) @(posedge clk);
        if (gap > 0) #1;
    endtask

    task automatic wait_done(output int n);
        bit seen;
        seen = 1'b0;
        n = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            n++;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk("done_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; length = 8'd0;
        in_valid = 1'b0; in_a = 8'd0; in_b = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd0);
        chk("rst_acc", 64'(acc_out), 64'd0);
        chk("rst_skip", 64'(skip_count), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: back-to-back pairs with one zero operand
        do_start(8'd3);
        chk("t1_busy", 64'(busy), 64'd1);
        send_pair(8'd5, 8'd3, 0);
        send_pair(8'd0, 8'd7, 0);
        send_pair(8'd12, 8'd10, 0);
        chk("t1_ready_low", 64'(in_ready), 64'd0);
        wait_done(lat);
        chk("t1_latency", 64'(lat), 64'd3);
        chk("t1_acc", 64'(acc_out), 64'd135);
        chk("t1_skip", 64'(skip_count), 64'd1);
        @(negedge clk);
        chk("t1_done_pulse", 64'(done), 64'd0);
        chk("t1_busy_low", 64'(busy), 64'd0);
        chk("t1_acc_hold", 64'(acc_out), 64'd135);

        // 2: max operands with idle gaps between valids
        @(posedge clk); #1;
        hs_cnt = 0;
        do_start(8'd4);
        send_pair(8'd255, 8'd255, 1);
        send_pair(8'd255, 8'd255, 2);
        send_pair(8'd255, 8'd255, 1);
        send_pair(8'd255, 8'd255, 0);
        wait_done(lat);
        chk("t2_acc", 64'(acc_out), 64'd260100);
        chk("t2_skip", 64'(skip_count), 64'd0);
        chk("t2_hs", 64'(hs_cnt), 64'd4);

        // 3: zero-length run
        @(posedge clk); #1;
        @(posedge clk); #1;
        ready_seen = 0;
        done_cnt = 0;
        do_start(8'd0);
        @(negedge clk);
        chk("t3_done", 64'(done), 64'd1);
        chk("t3_acc", 64'(acc_out), 64'd0);
        chk("t3_skip", 64'(skip_count), 64'd0);
        repeat (3) @(negedge clk);
        chk("t3_no_ready", 64'(ready_seen), 64'd0);
        chk("t3_one_done", 64'(done_cnt), 64'd1);

        // 4: in_valid in IDLE, then a second start during RUN
        @(posedge clk); #1;
        hs_cnt = 0;
        in_a = 8'd9; in_b = 8'd9; in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("t4_idle_hs", 64'(hs_cnt), 64'd0);
        do_start(8'd3);
        send_pair(8'd2, 8'd3, 0);
        do_start(8'd7);
        send_pair(8'd0, 8'd4, 0);
        send_pair(8'd6, 8'd6, 0);
        wait_done(lat);
        chk("t4_acc", 64'(acc_out), 64'd42);
        chk("t4_skip", 64'(skip_count), 64'd1);
        chk("t4_hs", 64'(hs_cnt), 64'd3);

        // 5: reset mid-run, then a fresh run
        @(posedge clk); #1;
        do_start(8'd5);
        send_pair(8'd1, 8'd1, 0);
        send_pair(8'd0, 8'd9, 0);
        rst = 1'b1;
        done_cnt = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_acc", 64'(acc_out), 64'd0);
        chk("t5_skip", 64'(skip_count), 64'd0);
        repeat (4) @(negedge clk);
        chk("t5_no_done", 64'(done_cnt), 64'd0);
        @(posedge clk); #1;
        do_start(8'd2);
        send_pair(8'd2, 8'd3, 0);
        send_pair(8'd4, 8'd5, 0);
        wait_done(lat);
        chk("t5_acc2", 64'(acc_out), 64'd26);
        chk("t5_skip2", 64'(skip_count), 64'd0);

        // 6: accumulator wrap in the 16-bit copy
        @(posedge clk); #1;
        do_start(8'd2);
        send_pair(8'd255, 8'd255, 0);
        send_pair(8'd255, 8'd255, 0);
        wait_done(lat);
        chk("t6_done16", 64'(done16), 64'd1);
        chk("t6_acc16", 64'(acc_out16), 64'd64514);
        chk("t6_acc32", 64'(acc_out), 64'd130050);
        chk("t6_skip16", 64'(skip_count16), 64'd0);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
